// File: rtl/hssl_tx_sync.sv
// Transmit-side link synchroniser: ALIGN commas until the far end locks, then frames/IDLE with periodic CC sequences.
// Optional statistics counters are compiled in with HSSL_TX_STATS_EN.
module hssl_tx_sync #(
  parameter int ALIGN_WORDS = 16,
  parameter int CC_INTERVAL = 5000,
  parameter int CC_LEN      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  loss_of_sync_state_in,
  input  logic [31:0] frm_data_in,
  input  logic [3:0]  frm_charisk_in,
  input  logic        frm_vld_in,
  output logic        frm_rdy_out,
  output logic [31:0] tx_data_out,
  output logic [3:0]  tx_charisk_out,
  output logic [1:0]  tx_state_out
`ifdef HSSL_TX_STATS_EN
  ,
  output logic [15:0] cc_seq_cnt_out,
  output logic [7:0]  realign_cnt_out
`endif
);

  localparam int CCW  = $clog2(CC_INTERVAL);
  localparam int AW_W = $clog2(ALIGN_WORDS + 1);

  localparam logic [CCW-1:0]  CC_LAST    = CCW'(CC_INTERVAL - 1);
  localparam logic [AW_W-1:0] ALIGN_DONE = AW_W'(ALIGN_WORDS);
  localparam logic [3:0]      CC_LEN_L   = 4'(CC_LEN);

  localparam logic [31:0] W_ALIGN = 32'h5050_50BC;
  localparam logic [31:0] W_IDLE  = 32'h4A4A_4ABC;
  localparam logic [31:0] W_CC    = 32'h1C1C_1C1C;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_CC    = 2'b01,
    S_ALIGN = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      k_q, k_d;
  logic [AW_W-1:0] align_q, align_d;
  logic [CCW-1:0]  cc_q, cc_d;
  logic [3:0]      len_q, len_d;
  logic            to_align, cc_done;
  logic            loss;

  // 2'b11 is not a legal sync state, so anything with bit 1 set counts as loss.
  assign loss = loss_of_sync_state_in[1];

  always_comb begin
    state_d     = state_q;
    data_d      = W_ALIGN;
    k_d         = 4'b0001;
    align_d     = align_q;
    cc_d        = cc_q;
    len_d       = len_q;
    to_align    = 1'b0;
    cc_done     = 1'b0;
    frm_rdy_out = (state_q == S_RUN) && (cc_q != CC_LAST) && !loss;
    case (state_q)
      S_ALIGN: begin
        cc_d = '0;
        if (align_q != ALIGN_DONE) align_d = align_q + AW_W'(1);
        if (align_q == ALIGN_DONE && loss_of_sync_state_in == 2'b00) state_d = S_RUN;
      end
      S_RUN: begin
        if (loss) begin
          to_align = 1'b1;
        end else if (cc_q == CC_LAST) begin
          state_d = S_CC;
          data_d  = W_CC;
          k_d     = 4'b1111;
          cc_d    = '0;
          len_d   = 4'd1;
        end else begin
          if (frm_vld_in) begin
            data_d = frm_data_in;
            k_d    = frm_charisk_in;
          end else begin
            data_d = W_IDLE;
          end
          cc_d = cc_q + CCW'(1);
        end
      end
      S_CC: begin
        if (loss) begin
          to_align = 1'b1;
        end else if (len_q < CC_LEN_L) begin
          data_d = W_CC;
          k_d    = 4'b1111;
          len_d  = len_q + 4'd1;
        end else begin
          // Exit cycle: rdy is still low here, so no frame can be taken.
          state_d = S_RUN;
          data_d  = W_IDLE;
          cc_d    = CCW'(1);
          cc_done = 1'b1;
        end
      end
      default: to_align = 1'b1;
    endcase
    if (to_align) begin
      state_d = S_ALIGN;
      data_d  = W_ALIGN;
      k_d     = 4'b0001;
      align_d = AW_W'(1);
      cc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ALIGN;
      data_q  <= W_ALIGN;
      k_q     <= 4'b0001;
      align_q <= '0;
      cc_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      align_q <= align_d;
      cc_q    <= cc_d;
      len_q   <= len_d;
    end
  end

  assign tx_data_out    = data_q;
  assign tx_charisk_out = k_q;
  assign tx_state_out   = state_q;

`ifdef HSSL_TX_STATS_EN
  logic [15:0] ccseq_q;
  logic [7:0]  realign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ccseq_q   <= '0;
      realign_q <= '0;
    end else begin
      if (cc_done && ccseq_q != 16'hFFFF) ccseq_q <= ccseq_q + 16'd1;
      if (to_align && (state_q == S_RUN || state_q == S_CC) && realign_q != 8'hFF)
        realign_q <= realign_q + 8'd1;
    end
  end

  assign cc_seq_cnt_out  = ccseq_q;
  assign realign_cnt_out = realign_q;
`endif

endmodule

// File: tb/tb_hssl_tx_sync.sv
// Self-checking bench for hssl_tx_sync: directed vector table, hand sequences and random traffic vs a reference model.
module tb_hssl_tx_sync;
  localparam int AW  = 16;
  localparam int CCI = 8;
  localparam int CCL = 2;

  localparam logic [31:0] W_ALIGN = 32'h5050_50BC;
  localparam logic [31:0] W_IDLE  = 32'h4A4A_4ABC;
  localparam logic [31:0] W_CC    = 32'h1C1C_1C1C;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  los;
  logic [31:0] fdata;
  logic [3:0]  fk;
  logic        fvld;
  logic        frdy;
  logic [31:0] txd;
  logic [3:0]  txk;
  logic [1:0]  txs;
`ifdef HSSL_TX_STATS_EN
  logic [15:0] ccseq;
  logic [7:0]  realign;
`endif

  always #5 clk = ~clk;

  hssl_tx_sync #(.ALIGN_WORDS(AW), .CC_INTERVAL(CCI), .CC_LEN(CCL)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .loss_of_sync_state_in (los),
    .frm_data_in           (fdata),
    .frm_charisk_in        (fk),
    .frm_vld_in            (fvld),
    .frm_rdy_out           (frdy),
    .tx_data_out           (txd),
    .tx_charisk_out        (txk),
    .tx_state_out          (txs)
`ifdef HSSL_TX_STATS_EN
    ,
    .cc_seq_cnt_out        (ccseq),
    .realign_cnt_out       (realign)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: link mode plus "ALIGN words sent", "run cycles since last CC"
  // and "CC words still owed" bookkeeping.
  typedef enum {M_ALIGN, M_RUN, M_CC} mmode_e;
  mmode_e m_mode;
  int m_align_n, m_run_n, m_cc_left, m_realign, m_ccseq;

  task automatic model_reset();
    m_mode = M_ALIGN; m_align_n = 0; m_run_n = 0; m_cc_left = 0; m_realign = 0; m_ccseq = 0;
  endtask

  task automatic model_cycle(input logic [1:0] l, input logic v, input logic [31:0] d,
                             input logic [3:0] k, output logic [31:0] ed, output logic [3:0] ek,
                             output logic er, output logic [1:0] es);
    bit lost = l[1];
    ed = W_ALIGN; ek = 4'h1; er = 1'b0; es = 2'b10;
    case (m_mode)
      M_ALIGN: begin
        m_run_n = 0;
        if (m_align_n >= AW && l == 2'b00) m_mode = M_RUN;
        m_align_n = (m_align_n < AW) ? m_align_n + 1 : AW;
      end
      M_RUN: begin
        es = 2'b00;
        er = (m_run_n != CCI - 1) && !lost;
        if (lost) begin
          m_mode = M_ALIGN; m_align_n = 1;
          if (m_realign < 255) m_realign++;
        end else if (m_run_n == CCI - 1) begin
          ed = W_CC; ek = 4'hF; m_mode = M_CC; m_cc_left = CCL - 1; m_run_n = 0;
        end else begin
          if (v) begin ed = d; ek = k; end
          else ed = W_IDLE;
          m_run_n++;
        end
      end
      default: begin
        es = 2'b01;
        if (lost) begin
          m_mode = M_ALIGN; m_align_n = 1;
          if (m_realign < 255) m_realign++;
        end else if (m_cc_left > 0) begin
          ed = W_CC; ek = 4'hF; m_cc_left--;
        end else begin
          ed = W_IDLE; m_mode = M_RUN; m_run_n = 1;
          if (m_ccseq < 65535) m_ccseq++;
        end
      end
    endcase
  endtask

  task automatic drive(input logic [1:0] l, input logic v, input logic [31:0] d, input logic [3:0] k);
    los = l; fvld = v; fdata = d; fk = k;
  endtask

  // One cycle: inputs driven after an edge, rdy/state checked mid-cycle, data checked after the edge.
  task automatic step(input logic [1:0] l, input logic v, input logic [31:0] d, input logic [3:0] k);
    logic [31:0] ed; logic [3:0] ek; logic er; logic [1:0] es;
    drive(l, v, d, k);
    #2;
    model_cycle(l, v, d, k, ed, ek, er, es);
    chk("state", txs, es);
    if (l != 2'b11) chk("rdy", frdy, er);
    @(posedge clk); #1;
    chk("data", txd, ed);
    chk("charisk", txk, ek);
`ifdef HSSL_TX_STATS_EN
    chk("realign_cnt", realign, m_realign);
    chk("cc_seq_cnt", ccseq, m_ccseq);
`endif
  endtask

  typedef struct {
    logic [1:0]  l;
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        er;
  } vec_t;
  vec_t vec[31];

  function automatic logic [1:0] rnd_los();
    int r = int'($urandom_range(0, 299));
    return (r < 3) ? 2'b10 : (r < 20) ? 2'b01 : 2'b00;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ed; logic [3:0] ek; logic er; logic [1:0] es;
    int guard;

    // Release with loss held, lock from cycle 3; 8 frames offered back-to-back,
    // interrupted by a CC sequence (rdy is low for the CC-start cycle and both CC-state cycles).
    for (int c = 0; c < 17; c++) vec[c] = '{(c < 3) ? 2'b10 : 2'b00, 1'b0, 32'h0, 4'h0, W_ALIGN, 4'h1, 1'b0};
    vec[17] = '{2'b00, 1'b0, 32'h0, 4'h0, W_IDLE, 4'h1, 1'b1};
    vec[18] = '{2'b00, 1'b0, 32'h0, 4'h0, W_IDLE, 4'h1, 1'b1};
    for (int i = 1; i <= 5; i++) vec[18+i] = '{2'b00, 1'b1, 32'(i), 4'h0, 32'(i), 4'h0, 1'b1};
    vec[24] = '{2'b00, 1'b1, 32'd6, 4'h0, W_CC, 4'hF, 1'b0};
    vec[25] = '{2'b00, 1'b1, 32'd6, 4'h0, W_CC, 4'hF, 1'b0};
    vec[26] = '{2'b00, 1'b1, 32'd6, 4'h0, W_IDLE, 4'h1, 1'b0};
    for (int i = 6; i <= 8; i++) vec[21+i] = '{2'b00, 1'b1, 32'(i), 4'h0, 32'(i), 4'h0, 1'b1};
    vec[30] = '{2'b00, 1'b0, 32'h0, 4'h0, W_IDLE, 4'h1, 1'b1};

    reset = 1'b0;
    drive(2'b10, 1'b0, 32'h0, 4'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", txd, W_ALIGN);
    chk("rst_charisk", txk, 4'h1);
    chk("rst_rdy", frdy, 1'b0);
    chk("rst_state", txs, 2'b10);
`ifdef HSSL_TX_STATS_EN
    chk("rst_realign", realign, 0);
    chk("rst_ccseq", ccseq, 0);
`endif
    reset = 1'b1;
    model_reset();

    for (int c = 0; c < 31; c++) begin
      drive(vec[c].l, vec[c].v, vec[c].d, vec[c].k);
      #2;
      model_cycle(vec[c].l, vec[c].v, vec[c].d, vec[c].k, ed, ek, er, es);
      chk($sformatf("vec%0d_rdy", c), frdy, vec[c].er);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_data", c), txd, vec[c].ed);
      chk($sformatf("vec%0d_k", c), txk, vec[c].ek);
    end

    // Continuous offer across several CC sequences.
    repeat (30) step(2'b00, 1'b1, $urandom, 4'h0);

    // Loss during the first CC word aborts the sequence.
    guard = 0;
    while (m_mode != M_CC && guard < 20) begin
      step(2'b00, 1'b1, $urandom, 4'h0);
      guard++;
    end
    if (guard >= 20) begin
      errors++;
      $display("FAIL cc_reach: no CC sequence within 20 cycles, expected one");
    end
    step(2'b10, 1'b1, $urandom, 4'h0);
    chk("abort_data", txd, W_ALIGN);
`ifdef HSSL_TX_STATS_EN
    chk("abort_realign", realign, 1);
`endif
    repeat (3) step(2'b10, 1'b1, $urandom, 4'h0);
    repeat (25) step(2'b00, $urandom_range(0, 1), $urandom, 4'h0);

    // Resync keeps transmitting; illegal sync state forces realignment.
    repeat (6) step(2'b01, 1'b1, $urandom, $urandom);
    step(2'b11, 1'b0, 32'h0, 4'h0);
    chk("illegal_los_state", txs, 2'b10);
    repeat (20) step(2'b00, 1'b0, 32'h0, 4'h0);

    for (int i = 0; i < 3000; i++) step(rnd_los(), $urandom_range(0, 1), $urandom, $urandom);

    // Reset in the middle of a burst takes effect without a clock edge.
    repeat (40) step(2'b00, 1'b1, $urandom, 4'h0);
    drive(2'b00, 1'b1, 32'hDEAD_BEEF, 4'h0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_data", txd, W_ALIGN);
    chk("async_rst_k", txk, 4'h1);
    chk("async_rst_rdy", frdy, 1'b0);
    chk("async_rst_state", txs, 2'b10);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    repeat (25) step(2'b00, 1'b1, $urandom, 4'h0);

    // Held loss keeps the link in ALIGN indefinitely.
    repeat (40) step(2'b10, $urandom_range(0, 1), $urandom, 4'h0);
    chk("hold_loss_state", txs, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
